// File: rtl/inverse_sub_bytes_sequencer_if.sv
// Bus bundle for the AES InvSubBytes engine.
// Handshake rules, both directions: a transfer happens on the rising clock
// edge where valid and ready are both high. The producer keeps valid and its
// data stable until that edge. The consumer may raise or lower ready at any
// time. i_flush is a synchronous abort that overrides both handshakes.
interface inverse_sub_bytes_sequencer_if #(
  parameter int NB_STATE = 128
);
  logic [NB_STATE-1:0] i_state;
  logic                i_valid;
  logic                o_ready;
  logic                i_flush;
  logic [NB_STATE-1:0] o_state;
  logic                o_valid;
  logic                i_ready;

  // The engine is the slave: it consumes i_* and drives o_*.
  modport slave (
    input  i_state, i_valid, i_flush, i_ready,
    output o_ready, o_state, o_valid
  );

  // The surrounding datapath is the master.
  modport master (
    output i_state, i_valid, i_flush, i_ready,
    input  o_ready, o_state, o_valid
  );
endinterface

// File: rtl/inverse_sub_bytes_sequencer.sv
// AES InvSubBytes engine. It accepts one 128-bit state and replaces NB_LANES
// bytes per clock in place. Each byte goes through the inverse affine map and
// then the GF(2^8) inverse. The finished state is held until downstream takes it.
module inverse_sub_bytes_sequencer #(
  parameter int NB_BYTE  = 8,
  parameter int NB_STATE = 128,
  parameter int NB_LANES = 4
) (
  input  logic                          i_clock,
  input  logic                          i_reset_n,
  inverse_sub_bytes_sequencer_if.slave  bus,
  output logic [1:0]                    o_dbg_state
);

  localparam int NB_BYTES  = NB_STATE / NB_BYTE;
  localparam int NB_ITER   = NB_BYTES / NB_LANES;
  localparam int CNT_W     = (NB_ITER > 1) ? $clog2(NB_ITER) : 1;
  localparam int BIT_W     = $clog2(NB_STATE);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(NB_ITER - 1);

  // Reject configurations the datapath was not built for (BAD_CONF).
  if (NB_BYTE != 8 || NB_STATE != 128 ||
      !(NB_LANES == 1 || NB_LANES == 2 || NB_LANES == 4 ||
        NB_LANES == 8 || NB_LANES == 16)) begin : g_bad_conf
    $error("BAD_CONF: NB_BYTE=%0d NB_STATE=%0d NB_LANES=%0d", NB_BYTE, NB_STATE, NB_LANES);
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    iter_q;
  logic [NB_STATE-1:0] work_q;
  logic [NB_STATE-1:0] work_next;
  logic [NB_STATE-1:0] out_q;
  logic                ready_q;
  logic                valid_q;
  logic [NB_BYTE-1:0]  lane_in  [NB_LANES];
  logic [NB_BYTE-1:0]  lane_out [NB_LANES];

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1, shift-and-add form.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // Multiplicative inverse as x^254, built from the squares x^2..x^128.
  // The input 0 gives 0 here, which is the inverse(0)=0 convention.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = x;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  // Inverse S-box: undo the affine map first, then invert in the field.
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] a;
    a = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(a);
  endfunction

  // Bit offset of byte k. Byte 0 is the most significant byte.
  function automatic logic [BIT_W-1:0] byte_lsb(input int k);
    return BIT_W'(NB_STATE - NB_BYTE * (k + 1));
  endfunction

  // Pick the bytes this iteration works on.
  always_comb begin
    for (int j = 0; j < NB_LANES; j++) begin
      lane_in[j] = work_q[byte_lsb(int'(iter_q) * NB_LANES + j) +: NB_BYTE];
    end
  end

  // One inverse S-box per lane.
  for (genvar j = 0; j < NB_LANES; j++) begin : g_lane
    assign lane_out[j] = inv_sbox(lane_in[j]);
  end

  // Write the substituted bytes back into their slots; all other bytes pass through.
  always_comb begin
    work_next = work_q;
    for (int j = 0; j < NB_LANES; j++) begin
      work_next[byte_lsb(int'(iter_q) * NB_LANES + j) +: NB_BYTE] = lane_out[j];
    end
  end

  // Control FSM. It owns the working register and every registered output.
  // Flush has priority over both the accept handshake and the output handshake.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      iter_q  <= '0;
      work_q  <= '0;
      out_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else if (bus.i_flush) begin
      state_q <= IDLE;
      iter_q  <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_valid && ready_q) begin
            work_q  <= bus.i_state;
            iter_q  <= '0;
            ready_q <= 1'b0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          work_q <= work_next;
          if (iter_q == LAST_ITER) begin
            out_q   <= work_next;
            valid_q <= 1'b1;
            state_q <= DONE;
          end else begin
            iter_q <= iter_q + 1'b1;
          end
        end
        DONE: begin
          if (bus.i_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          iter_q  <= '0;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_ready = ready_q;
  assign bus.o_valid = valid_q;
  assign bus.o_state = out_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_inverse_sub_bytes_sequencer.sv
// Directed bench for inverse_sub_bytes_sequencer. It uses a main 4-lane
// instance and a sweep of instances with 1, 2, 4, 8 and 16 lanes.
module tb_inverse_sub_bytes_sequencer;
  localparam int W = 128;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT ----------------
  inverse_sub_bytes_sequencer_if #(.NB_STATE(W)) bus ();
  logic [1:0] dbg;

  inverse_sub_bytes_sequencer #(.NB_BYTE(8), .NB_STATE(W), .NB_LANES(4)) dut (
    .i_clock     (clk),
    .i_reset_n   (rst_n),
    .bus         (bus.slave),
    .o_dbg_state (dbg)
  );

  // ---------------- lane sweep DUTs ----------------
  logic [W-1:0] sw_state;
  logic         sw_valid;
  logic [4:0]   sw_ovalid;
  logic [4:0]   sw_oready;
  logic [9:0]   sw_dbg;
  logic [W-1:0] sw_out [5];

  for (genvar g = 0; g < 5; g++) begin : g_sweep
    inverse_sub_bytes_sequencer_if #(.NB_STATE(W)) sbus ();
    logic [1:0] sdbg;
    assign sbus.i_state = sw_state;
    assign sbus.i_valid = sw_valid;
    assign sbus.i_flush = 1'b0;
    assign sbus.i_ready = 1'b1;
    assign sw_ovalid[g] = sbus.o_valid;
    assign sw_oready[g] = sbus.o_ready;
    assign sw_out[g]    = sbus.o_state;
    assign sw_dbg[2*g +: 2] = sdbg;
    inverse_sub_bytes_sequencer #(.NB_BYTE(8), .NB_STATE(W), .NB_LANES(1 << g)) u_dut (
      .i_clock     (clk),
      .i_reset_n   (rst_n),
      .bus         (sbus.slave),
      .o_dbg_state (sdbg)
    );
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  logic [7:0] sbox_tbl [256];

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference forward S-box ----------------
  function automatic logic [7:0] ref_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  // Brute-force field inverse followed by the forward affine map.
  function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
    logic [7:0] b;
    b = 8'h00;
    if (x != 8'h00) begin
      for (int y = 1; y < 256; y++) begin
        if (ref_gmul(x, 8'(y)) == 8'h01) b = 8'(y);
      end
    end
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // Forward-substitute every byte of a state. The DUT must undo this.
  function automatic logic [W-1:0] apply_sbox(input logic [W-1:0] s);
    logic [W-1:0] r;
    logic [W-1:0] t;
    r = '0;
    t = s;
    for (int k = 0; k < 16; k++) begin
      r = {r[W-9:0], sbox_tbl[t[W-1 -: 8]]};
      t = t << 8;
    end
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input string tag, input logic [W-1:0] st, input logic [W-1:0] ex);
    chk({tag, "_ready_in"}, W'(bus.o_ready), W'(1));
    bus.i_state = st;
    bus.i_valid = 1'b1;
    exp_q.push_back(ex);
    step();
    bus.i_valid = 1'b0;
    bus.i_state = '0;
  endtask

  task automatic wait_valid(input string tag, input int exp_lat);
    int n;
    logic [W-1:0] ex;
    n = 0;
    while (!bus.o_valid && n < 64) begin
      step();
      n++;
    end
    chk({tag, "_lat"}, W'(n), W'(exp_lat));
    ex = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    chk({tag, "_state"}, bus.o_state, ex);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] st;
    logic [W-1:0] ex;
    logic [W-1:0] exp4;
    logic any_v;
    int lat [5];
    logic [W-1:0] got_sw [5];
    logic [W-1:0] exp_sw;

    for (int i = 0; i < 256; i++) sbox_tbl[i] = fwd_sbox(8'(i));

    bus.i_state = '0;
    bus.i_valid = 1'b0;
    bus.i_flush = 1'b0;
    bus.i_ready = 1'b1;
    sw_state    = '0;
    sw_valid    = 1'b0;

    // Test 1: reset held 3 cycles, then stable reset values.
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("rst_valid", W'(bus.o_valid), W'(0));
    chk("rst_ready", W'(bus.o_ready), W'(1));
    chk("rst_state", bus.o_state, '0);
    chk("rst_fsm",   W'(dbg), W'(0));
    repeat (3) step();
    chk("rst_stable_state", bus.o_state, '0);
    chk("rst_stable_valid", W'(bus.o_valid), W'(0));

    // Test 2: InvSbox(63)=00 in every byte, latency 4.
    send("t2", {16{8'h63}}, {16{8'h00}});
    wait_valid("t2", 4);
    step();
    chk("t2_back_idle_ready", W'(bus.o_ready), W'(1));
    chk("t2_back_idle_valid", W'(bus.o_valid), W'(0));

    // Test 3: byte ordering. 7C->01, 00->52, 01->09, ED->53, 63->00.
    send("t3", 128'h7C00_01ED_6300_0000_0000_0000_0000_0000,
               128'h0152_0953_0052_5252_5252_5252_5252_5252);
    wait_valid("t3", 4);
    step();

    // Test 4: backpressure for 10 cycles with a stray second valid.
    exp4 = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
    bus.i_ready = 1'b0;
    send("t4", apply_sbox(exp4), exp4);
    wait_valid("t4", 4);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        bus.i_state = {16{8'hA5}};
        bus.i_valid = 1'b1;
      end
      step();
      bus.i_valid = 1'b0;
      chk("t4_hold_valid", W'(bus.o_valid), W'(1));
      chk("t4_hold_state", bus.o_state, exp4);
      chk("t4_hold_ready", W'(bus.o_ready), W'(0));
    end
    bus.i_ready = 1'b1;
    step();
    chk("t4_release_valid", W'(bus.o_valid), W'(0));
    chk("t4_release_ready", W'(bus.o_ready), W'(1));
    chk("t4_release_fsm",   W'(dbg), W'(0));
    any_v = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      any_v = any_v | bus.o_valid;
    end
    chk("t4_not_queued", W'(any_v), W'(0));

    // Test 5: flush after two BUSY cycles, then a clean transaction.
    send("t5", apply_sbox({16{8'h3C}}), {16{8'h3C}});
    void'(exp_q.pop_back());
    step();
    step();
    chk("t5_busy_fsm", W'(dbg), W'(1));
    bus.i_flush = 1'b1;
    step();
    bus.i_flush = 1'b0;
    chk("t5_flush_valid", W'(bus.o_valid), W'(0));
    chk("t5_flush_ready", W'(bus.o_ready), W'(1));
    chk("t5_flush_fsm",   W'(dbg), W'(0));
    chk("t5_flush_keeps_state", bus.o_state, exp4);
    any_v = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      any_v = any_v | bus.o_valid;
    end
    chk("t5_no_valid", W'(any_v), W'(0));
    ex = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_FEDC_BA98;
    send("t5b", apply_sbox(ex), ex);
    wait_valid("t5b", 4);
    step();

    // Asynchronous reset in the middle of BUSY.
    send("t5r", apply_sbox({16{8'h77}}), {16{8'h77}});
    void'(exp_q.pop_back());
    step();
    rst_n = 1'b0;
    #1;
    chk("t5r_valid", W'(bus.o_valid), W'(0));
    chk("t5r_ready", W'(bus.o_ready), W'(1));
    chk("t5r_state", bus.o_state, '0);
    chk("t5r_fsm",   W'(dbg), W'(0));
    #2;
    rst_n = 1'b1;
    step();

    // Test 6: every byte value in every position; the DUT must invert the S-box.
    for (int v = 0; v < 256; v++) begin
      st = '0;
      ex = '0;
      for (int k = 0; k < 16; k++) begin
        ex = {ex[W-9:0], 8'(v + k)};
        st = {st[W-9:0], sbox_tbl[8'(v + k)]};
      end
      send("exh", st, ex);
      wait_valid("exh", 4);
      step();
    end

    // Latency across lane counts: NB_ITER = 16 / NB_LANES.
    exp_sw = 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;
    for (int gi = 0; gi < 5; gi++) begin
      lat[gi]    = 0;
      got_sw[gi] = '0;
    end
    sw_state = apply_sbox(exp_sw);
    sw_valid = 1'b1;
    step();
    sw_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      step();
      for (int gi = 0; gi < 5; gi++) begin
        if (sw_ovalid[gi] && lat[gi] == 0) begin
          lat[gi]    = c;
          got_sw[gi] = sw_out[gi];
        end
      end
    end
    for (int gi = 0; gi < 5; gi++) begin
      chk($sformatf("sweep_lanes%0d_lat", 1 << gi), W'(lat[gi]), W'(16 >> gi));
      chk($sformatf("sweep_lanes%0d_state", 1 << gi), got_sw[gi], exp_sw);
    end
    chk("sweep_idle_ready", W'(sw_oready), W'(5'h1f));
    chk("sweep_idle_fsm",   W'(sw_dbg), W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
